// File: rtl/snn_timestep_scheduler.sv
// ============================================================================
// Module   : snn_timestep_scheduler
// Function : Sequences one SNN inference (clear, feed, drain) and picks the
//            winning output neuron by sequential argmax over spike counts.
// Revision : 1.0
// ============================================================================
`default_nettype none

module snn_timestep_scheduler #(
    parameter int N_IN      = 8,
    parameter int N_OUT     = 8,
    parameter int T_STEPS   = 16,
    parameter int LAYER_LAT = 2,
    parameter int CNT_W     = 5,
    parameter int IDX_W     = 3,
    localparam int STEP_W   = $clog2(T_STEPS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in_spike,
    output logic              net_clear,
    output logic              net_step,
    output logic [N_IN-1:0]   net_spike_in,
    input  logic [N_OUT-1:0]  net_spike_out,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  class_idx,
    output logic [CNT_W-1:0]  class_count,
    output logic [STEP_W-1:0] step_cnt
);

    localparam int DRAIN_W = $clog2(LAYER_LAT + 1) + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_FEED   = 3'd2,
        S_DRAIN  = 3'd3,
        S_ARGMAX = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t               r_state;
    logic                 r_net_clear;
    logic                 r_net_step;
    logic [N_IN-1:0]      r_spike_in;
    logic                 r_done;
    logic [STEP_W-1:0]    r_step_cnt;
    logic [DRAIN_W-1:0]   r_drain;
    logic [LAYER_LAT-1:0] r_step_pipe;
    logic [CNT_W-1:0]     r_cnt [N_OUT];
    logic [IDX_W-1:0]     r_j;
    logic [CNT_W-1:0]     r_best;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     r_class_idx;
    logic [CNT_W-1:0]     r_class_count;

    logic                 w_cap_vld;
    logic                 w_take;
    logic [CNT_W-1:0]     w_best_nx;
    logic [IDX_W-1:0]     w_idx_nx;

    assign w_cap_vld = r_step_pipe[LAYER_LAT-1];

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        w_take    = (r_j == '0) || (r_cnt[r_j] > r_best);
        w_best_nx = w_take ? r_cnt[r_j] : r_best;
        w_idx_nx  = w_take ? r_j : r_idx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_net_clear   <= 1'b0;
            r_net_step    <= 1'b0;
            r_spike_in    <= '0;
            r_done        <= 1'b0;
            r_step_cnt    <= '0;
            r_drain       <= '0;
            r_step_pipe   <= '0;
            r_j           <= '0;
            r_best        <= '0;
            r_idx         <= '0;
            r_class_idx   <= '0;
            r_class_count <= '0;
            for (int i = 0; i < N_OUT; i++) r_cnt[i] <= '0;
        end else begin
            r_net_clear    <= 1'b0;
            r_net_step     <= 1'b0;
            r_done         <= 1'b0;
            r_step_pipe[0] <= r_net_step;
            for (int k = 1; k < LAYER_LAT; k++) r_step_pipe[k] <= r_step_pipe[k-1];

            if (w_cap_vld) begin
                for (int i = 0; i < N_OUT; i++) begin
                    if (net_spike_out[i] && (r_cnt[i] != '1)) r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state       <= S_CLEAR;
                        r_net_clear   <= 1'b1;
                        r_step_cnt    <= '0;
                        r_best        <= '0;
                        r_idx         <= '0;
                        r_class_idx   <= '0;
                        r_class_count <= '0;
                        for (int i = 0; i < N_OUT; i++) r_cnt[i] <= '0;
                    end
                end
                S_CLEAR: r_state <= S_FEED;
                S_FEED: begin
                    if (in_valid) begin
                        r_spike_in <= in_spike;
                        r_net_step <= 1'b1;
                        r_step_cnt <= r_step_cnt + 1'b1;
                        if (r_step_cnt == STEP_W'(T_STEPS - 1)) begin
                            r_state <= S_DRAIN;
                            r_drain <= DRAIN_W'(LAYER_LAT);
                        end
                    end
                end
                // Holds LAYER_LAT+1 cycles so the last step's capture lands.
                S_DRAIN: begin
                    if (r_drain == '0) begin
                        r_state <= S_ARGMAX;
                        r_j     <= '0;
                    end else begin
                        r_drain <= r_drain - 1'b1;
                    end
                end
                S_ARGMAX: begin
                    r_best <= w_best_nx;
                    r_idx  <= w_idx_nx;
                    if (r_j == IDX_W'(N_OUT - 1)) begin
                        r_state       <= S_DONE;
                        r_done        <= 1'b1;
                        r_class_idx   <= w_idx_nx;
                        r_class_count <= w_best_nx;
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready     = (r_state == S_FEED);
    assign busy         = (r_state != S_IDLE);
    assign net_clear    = r_net_clear;
    assign net_step     = r_net_step;
    assign net_spike_in = r_spike_in;
    assign done         = r_done;
    assign class_idx    = r_class_idx;
    assign class_count  = r_class_count;
    assign step_cnt     = r_step_cnt;

endmodule

`default_nettype wire

// File: tb/tb_snn_timestep_scheduler.sv
// ============================================================================
// Module   : tb_snn_timestep_scheduler
// Function : Scoreboard bench for snn_timestep_scheduler with a 2-cycle
//            layer stub and directed spike patterns.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_snn_timestep_scheduler;

    localparam int N_IN   = 8;
    localparam int N_OUT  = 8;
    localparam int CNT_W  = 5;
    localparam int IDX_W  = 3;
    localparam int STEP_W = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [N_IN-1:0]   in_spike = '0;
    logic              net_clear;
    logic              net_step;
    logic [N_IN-1:0]   net_spike_in;
    logic [N_OUT-1:0]  net_spike_out;
    logic              busy;
    logic              done;
    logic [IDX_W-1:0]  class_idx;
    logic [CNT_W-1:0]  class_count;
    logic [STEP_W-1:0] step_cnt;

    snn_timestep_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_spike     (in_spike),
        .net_clear    (net_clear),
        .net_step     (net_step),
        .net_spike_in (net_spike_in),
        .net_spike_out(net_spike_out),
        .busy         (busy),
        .done         (done),
        .class_idx    (class_idx),
        .class_count  (class_count),
        .step_cnt     (step_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared = 0;
    int failed   = 0;
    int pat      = 0;
    int start_cyc = 0;

    task automatic chk(input string name, input int act, input int expv);
        compared++;
        if (act != expv) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [7:0] pattern(input int p, input int k);
        logic [7:0] v;
        v = '0;
        case (p)
            0: begin v[5] = (k < 10); v[2] = (k < 7); end
            1: begin v[3] = (k < 9); v[6] = (k >= 7); v[1] = (k < 8); v[0] = (k < 4); end
            3: begin v[7] = 1'b1; v[0] = (k < 15); v[4] = (k % 2 == 1); end
            default: v = '0;
        endcase
        return v;
    endfunction

    // Layer stub: spikes for step k appear LAYER_LAT cycles after its net_step;
    // random junk otherwise, which the scheduler must ignore.
    logic       s1_v = 1'b0, s2_v = 1'b0;
    int         s1_k = 0, s2_k = 0, k_ctr = 0;
    logic [7:0] junk = '0;
    always @(posedge clk) begin
        s1_v <= net_step;
        s1_k <= k_ctr;
        s2_v <= s1_v;
        s2_k <= s1_k;
        junk <= 8'($urandom);
        if (net_clear) k_ctr <= 0;
        else if (net_step) k_ctr <= k_ctr + 1;
    end
    assign net_spike_out = s2_v ? pattern(pat, s2_k) : junk;

    typedef struct {
        int idx;
        int cnt;
        int lat;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    int   n_step = 0;
    int   n_clear = 0;

    always @(negedge clk) begin
        if (reset) begin
            n_step  = 0;
            n_clear = 0;
        end else begin
            if (net_clear) begin
                n_clear++;
                chk("clear_step_overlap", int'(net_step), 0);
            end
            if (net_step) n_step++;
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("class_idx", int'(class_idx), e.idx);
                    chk("class_count", int'(class_count), e.cnt);
                    chk("done_latency", cyc - start_cyc, e.lat);
                    chk("net_step_pulses", n_step, 16);
                    chk("net_clear_pulses", n_clear, 1);
                    chk("step_cnt_final", int'(step_cnt), 16);
                end
                n_step  = 0;
                n_clear = 0;
            end
        end
    end

    // mode 0: in_valid constant, 1: toggling, 2: reset at step_cnt 7, 3: stray starts
    task automatic run_inf(input int p, input int mode);
        int rel;
        bit fin;
        pat = p;
        @(posedge clk); #1;
        start     = 1'b1;
        in_valid  = 1'b0;
        start_cyc = cyc;
        fin = 1'b0;
        while (!fin) begin
            @(posedge clk); #1;
            rel      = cyc - start_cyc;
            start    = (mode == 3) && (rel == 8 || rel == 24);
            in_valid = (mode == 1) ? (rel % 2 == 1) : 1'b1;
            in_spike = 8'($urandom);
            if (mode == 2 && busy && step_cnt == 5'd7) begin
                chk("pre_reset_net_step", int'(net_step), 1);
                #2 reset = 1'b1;
                #1;
                chk("rst_busy", int'(busy), 0);
                chk("rst_in_ready", int'(in_ready), 0);
                chk("rst_net_step", int'(net_step), 0);
                chk("rst_net_clear", int'(net_clear), 0);
                chk("rst_class_idx", int'(class_idx), 0);
                chk("rst_class_count", int'(class_count), 0);
                chk("rst_step_cnt", int'(step_cnt), 0);
                in_valid = 1'b0;
                @(posedge clk); #1;
                reset = 1'b0;
                fin = 1'b1;
            end else if (rel >= 2 && !busy) begin
                fin = 1'b1;
            end else if (rel > 300) begin
                chk("timeout", rel, 0);
                fin = 1'b1;
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_in_ready", int'(in_ready), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_outputs", int'({net_clear, net_step, net_spike_in, class_idx, class_count, step_cnt}), 0);
        reset = 1'b0;

        sb.push_back('{5, 10, 29});
        run_inf(0, 0);
        sb.push_back('{3, 9, 29});
        run_inf(1, 0);
        sb.push_back('{5, 10, 45});
        run_inf(0, 1);
        sb.push_back('{0, 0, 29});
        run_inf(2, 0);
        run_inf(0, 2);
        sb.push_back('{7, 16, 29});
        run_inf(3, 0);
        sb.push_back('{5, 10, 29});
        run_inf(0, 3);

        repeat (10) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

`default_nettype wire
